// File: rtl/mc_pkg.sv
// Shared types and constants for the multi-cycle control sequencer.
package mc_pkg;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_ALU, C_LW, C_SW, C_J, C_JR, C_BR, C_HALT, C_NOP
  } opclass_t;

  localparam logic [4:0] OP_ALU_MAX = 5'h0F;
  localparam logic [4:0] OP_LW      = 5'h10;
  localparam logic [4:0] OP_SW      = 5'h11;
  localparam logic [4:0] OP_J       = 5'h12;
  localparam logic [4:0] OP_JR      = 5'h13;
  localparam logic [4:0] OP_BR      = 5'h14;
  localparam logic [4:0] OP_HALT    = 5'h1F;

  localparam logic [1:0] PC_SRC_INC = 2'd0;
  localparam logic [1:0] PC_SRC_REL = 2'd1;
  localparam logic [1:0] PC_SRC_REG = 2'd2;

  localparam logic [1:0] COND_ALWAYS = 2'b00;
  localparam logic [1:0] COND_ZERO   = 2'b01;
  localparam logic [1:0] COND_NZERO  = 2'b10;
  localparam logic [1:0] COND_NEVER  = 2'b11;

  function automatic opclass_t decode_op(input logic [4:0] op);
    if (op <= OP_ALU_MAX) return C_ALU;
    case (op)
      OP_LW:   return C_LW;
      OP_SW:   return C_SW;
      OP_J:    return C_J;
      OP_JR:   return C_JR;
      OP_BR:   return C_BR;
      OP_HALT: return C_HALT;
      default: return C_NOP;
    endcase
  endfunction

  function automatic logic cond_met(input logic [1:0] cond, input logic zero);
    case (cond)
      COND_ALWAYS: return 1'b1;
      COND_ZERO:   return zero;
      COND_NZERO:  return !zero;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Counts consecutive wait cycles (req high, ready low); expired fires on the
// MEM_TIMEOUT-th such cycle. MEM_TIMEOUT = 0 disables it.
module mc_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic req,
  input  logic ready,
  input  logic clr,
  output logic expired
);

  generate
    if (MEM_TIMEOUT == 0) begin : g_off
      assign expired = 1'b0;
      wire unused_ok = ^{clk, req, ready, clr};
    end else begin : g_on
      localparam int W = $clog2(MEM_TIMEOUT + 1);
      logic [W-1:0] cnt;

      // cnt holds the number of wait cycles already seen before this one
      assign expired = req && !ready && (cnt == W'(MEM_TIMEOUT - 1));

      always_ff @(posedge clk) begin
        if (clr || !req || ready) cnt <= '0;
        else if (!expired)        cnt <= cnt + W'(1);
      end
    end
  endgenerate

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer with memory
// handshakes, HALT and a sticky bus-timeout. Optional perf counters: MC_PERF_CNT_EN.
module mc_sequencer
  import mc_pkg::*;
#(
  parameter int INSTR_W     = 24,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr,
  input  logic               zero,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  output logic               imem_req,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic               ir_we,
  output logic               pc_we,
  output logic [1:0]         pc_src,
  output logic               opnd_we,
  output logic               mdr_we,
  output logic               flag_we,
  output logic               reg_we,
  output logic               mem2reg,
  output logic               halted,
  output logic               bus_err,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   instr_cnt
);

  state_t   state;
  opclass_t cls;
  logic     rst_hold;   // first cycle after a sampled reset: everything quiet
  logic     expired;
  logic     tmr_ready, tmr_clr;

  wire unused_instr = ^instr[INSTR_W-1:8];

  // The timer only runs while parked in one of the two wait states
  assign tmr_ready = (state == S_FETCH) ? imem_ready : dmem_ready;
  assign tmr_clr   = rst || rst_hold || (state != S_FETCH && state != S_MEM);

  mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .req     (imem_req | dmem_req),
    .ready   (tmr_ready),
    .clr     (tmr_clr),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      cls      <= C_NOP;
      rst_hold <= 1'b1;
      bus_err  <= 1'b0;
    end else begin
      rst_hold <= 1'b0;
      if (!rst_hold) begin
        if (expired) begin
          state   <= S_HALT;
          bus_err <= 1'b1;
        end else begin
          case (state)
            S_FETCH:  if (imem_ready) state <= S_DECODE;
            S_DECODE: begin
              cls   <= decode_op(instr[6:2]);
              state <= S_EXEC;
            end
            S_EXEC: begin
              case (cls)
                C_ALU:       state <= S_WB;
                C_LW, C_SW:  state <= S_MEM;
                C_HALT:      state <= S_HALT;
                default:     state <= S_FETCH;
              endcase
            end
            S_MEM:    if (dmem_ready) state <= (cls == C_LW) ? S_WB : S_FETCH;
            S_WB:     state <= S_FETCH;
            default:  state <= S_HALT;
          endcase
        end
      end
    end
  end

  assign halted = (state == S_HALT);

  always_comb begin
    imem_req = !rst_hold && (state == S_FETCH);
    dmem_req = !rst_hold && (state == S_MEM);
    dmem_we  = dmem_req && (cls == C_SW);
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_src   = PC_SRC_INC;
    opnd_we  = 1'b0;
    mdr_we   = 1'b0;
    flag_we  = 1'b0;
    reg_we   = 1'b0;
    mem2reg  = 1'b0;
    if (!rst_hold && !expired) begin
      case (state)
        S_FETCH: begin
          ir_we = imem_ready;
          pc_we = imem_ready;
        end
        S_DECODE: opnd_we = 1'b1;
        S_EXEC: begin
          case (cls)
            C_ALU: flag_we = instr[7];
            C_J:   begin pc_we = 1'b1; pc_src = PC_SRC_REL; end
            C_JR:  begin pc_we = 1'b1; pc_src = PC_SRC_REG; end
            C_BR:  begin pc_we = cond_met(instr[1:0], zero); pc_src = PC_SRC_REL; end
            default: ;
          endcase
        end
        S_MEM: mdr_we = dmem_ready && (cls == C_LW);
        S_WB: begin
          reg_we  = 1'b1;
          mem2reg = (cls == C_LW);
        end
        default: ;
      endcase
    end
  end

`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_q, ins_q;
  logic             retire;

  // Timeout entry into HALT deliberately does not retire anything
  assign retire = !rst_hold &&
                  ((state == S_EXEC && !(cls inside {C_ALU, C_LW, C_SW})) ||
                   (state == S_MEM && dmem_ready && cls == C_SW) ||
                   (state == S_WB));

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      if (!rst_hold && state != S_HALT) cyc_q <= cyc_q + CNT_W'(1);
      if (retire)                       ins_q <= ins_q + CNT_W'(1);
    end
  end

  assign cycle_cnt = cyc_q;
  assign instr_cnt = ins_q;
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// Randomized self-checking bench for mc_sequencer against a per-instruction
// schedule model (cycle-by-cycle expected enables derived from the op rules).
module tb_mc_sequencer;
  localparam int TO = 4;
  localparam int CW = 32;

  localparam logic [13:0] M_IMREQ = 14'h2000, M_DMREQ = 14'h1000, M_DWE  = 14'h0800,
                          M_IRWE  = 14'h0400, M_PCWE  = 14'h0200, M_REG  = 14'h0100,
                          M_REL   = 14'h0080, M_OPWE  = 14'h0040, M_MDR  = 14'h0020,
                          M_FLWE  = 14'h0010, M_RGWE  = 14'h0008, M_M2R  = 14'h0004,
                          M_HALT  = 14'h0002, M_BERR  = 14'h0001;

  logic          clk = 1'b0, rst = 1'b1;
  logic [23:0]   instr = '0;
  logic          zero = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
  logic          imem_req, dmem_req, dmem_we, ir_we, pc_we, opnd_we, mdr_we;
  logic          flag_we, reg_we, mem2reg, halted, bus_err;
  logic [1:0]    pc_src;
  logic [CW-1:0] cycle_cnt, instr_cnt;
  logic [13:0]   outv;

  int            checks = 0, errs = 0;
  logic [CW-1:0] exp_cyc = '0, exp_ins = '0;
  logic          hlt;

  mc_sequencer #(.INSTR_W(24), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .opnd_we(opnd_we),
    .mdr_we(mdr_we), .flag_we(flag_we), .reg_we(reg_we), .mem2reg(mem2reg),
    .halted(halted), .bus_err(bus_err), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  assign outv = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, opnd_we,
                 mdr_we, flag_we, reg_we, mem2reg, halted, bus_err};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic rb();
    return $urandom_range(1, 0) != 0;
  endfunction

  // Called at posedge+1: apply readies, compare at negedge, return at next posedge+1
  task automatic cyc(input string tag, input logic ir, input logic dr, input logic [13:0] exp);
    imem_ready = ir;
    dmem_ready = dr;
    @(negedge clk);
    chk(tag, outv, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic cnt_chk(input string tag);
`ifdef MC_PERF_CNT_EN
    chk({tag, "_cyc"}, cycle_cnt, exp_cyc);
    chk({tag, "_ins"}, instr_cnt, exp_ins);
`else
    chk({tag, "_cyc"}, cycle_cnt, '0);
    chk({tag, "_ins"}, instr_cnt, '0);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_outs", outv, '0);
    exp_cyc = '0;
    exp_ins = '0;
    cnt_chk("rst_cnt");
    @(posedge clk);
    #1;
  endtask

  task automatic halt_chk(input logic [13:0] extra);
    repeat (3) cyc("halted", rb(), rb(), M_HALT | extra);
    cnt_chk("cnt_halt");
  endtask

  // One instruction: di fetch wait cycles, dd data-memory wait cycles
  task automatic run_instr(input logic [23:0] ins, input logic z, input int di,
                           input int dd, output logic h);
    logic [4:0]  op;
    logic        alu, lw, sw, jj, jr, br, hop, cm;
    logic [13:0] e, mm;
    int          n;
    op  = ins[6:2];
    alu = (op <= 5'h0F);
    lw  = (op == 5'h10);
    sw  = (op == 5'h11);
    jj  = (op == 5'h12);
    jr  = (op == 5'h13);
    br  = (op == 5'h14);
    hop = (op == 5'h1F);
    case (ins[1:0])
      2'b00:   cm = 1'b1;
      2'b01:   cm = z;
      2'b10:   cm = !z;
      default: cm = 1'b0;
    endcase
    h = 1'b0;
    instr = ins;
    zero = z;
    cnt_chk("cnt_pre");
    if (di >= TO) begin
      repeat (TO) cyc("fetch_wait", 1'b0, rb(), M_IMREQ);
      exp_cyc += TO;
      halt_chk(M_BERR);
      h = 1'b1;
      return;
    end
    for (int i = 0; i < di; i++) cyc("fetch_wait", 1'b0, rb(), M_IMREQ);
    cyc("fetch_rdy", 1'b1, rb(), M_IMREQ | M_IRWE | M_PCWE);
    cyc("decode", rb(), rb(), M_OPWE);
    n = di + 3;
    e = '0;
    if (alu && ins[7]) e = M_FLWE;
    if (jj)            e = M_PCWE | M_REL;
    if (jr)            e = M_PCWE | M_REG;
    if (br)            e = (cm ? M_PCWE : 14'h0) | M_REL;
    cyc("exec", rb(), rb(), e);
    if (lw || sw) begin
      mm = M_DMREQ | (sw ? M_DWE : 14'h0);
      if (dd >= TO) begin
        repeat (TO) cyc("mem_wait", rb(), 1'b0, mm);
        exp_cyc += n + TO;
        halt_chk(M_BERR);
        h = 1'b1;
        return;
      end
      for (int i = 0; i < dd; i++) cyc("mem_wait", rb(), 1'b0, mm);
      cyc("mem_rdy", rb(), 1'b1, mm | (lw ? M_MDR : 14'h0));
      n += dd + 1;
    end
    if (alu || lw) begin
      cyc("wb", rb(), rb(), M_RGWE | (lw ? M_M2R : 14'h0));
      n++;
    end
    exp_cyc += n;
    exp_ins += 1;
    if (hop) begin
      halt_chk('0);
      h = 1'b1;
    end
  endtask

  initial begin
    logic [4:0]  op;
    logic [23:0] ins;
    int          di, dd;

    do_reset();

    // Zero-wait ALU op 0x03 with sf=1
    run_instr({16'h0000, 1'b1, 5'h03, 2'b00}, 1'b0, 0, 0, hlt);
    // LW with data ready delayed 3 cycles
    run_instr({16'h1234, 1'b0, 5'h10, 2'b00}, 1'b0, 0, 3, hlt);
    // BR cond=zero, taken and not taken
    run_instr({16'h0000, 1'b0, 5'h14, 2'b01}, 1'b1, 0, 0, hlt);
    run_instr({16'h0000, 1'b0, 5'h14, 2'b01}, 1'b0, 0, 0, hlt);
    // Fetch timeout -> bus_err + HALT, cleared by reset
    run_instr({16'h0000, 1'b0, 5'h01, 2'b00}, 1'b0, TO, 0, hlt);
    do_reset();

    // Reset during a SW data wait
    instr = {16'h0000, 1'b0, 5'h11, 2'b00};
    cyc("sw_fetch", 1'b1, 1'b0, M_IMREQ | M_IRWE | M_PCWE);
    cyc("sw_decode", 1'b0, 1'b0, M_OPWE);
    cyc("sw_exec", 1'b0, 1'b0, '0);
    rst = 1'b1;
    cyc("sw_wait", 1'b0, 1'b0, M_DMREQ | M_DWE);
    rst = 1'b0;
    chk("rst_drop", outv, '0);
    exp_cyc = '0;
    exp_ins = '0;
    cnt_chk("rst_drop_cnt");
    @(posedge clk);
    #1;
    run_instr({16'h0000, 1'b0, 5'h05, 2'b00}, 1'b0, 1, 0, hlt);

    // Three zero-wait jumps then HALT
    do_reset();
    repeat (3) run_instr({16'h00AA, 1'b0, 5'h12, 2'b00}, 1'b0, 0, 0, hlt);
    run_instr({16'h0000, 1'b0, 5'h1F, 2'b00}, 1'b0, 0, 0, hlt);
`ifdef MC_PERF_CNT_EN
    chk("perf_cyc12", cycle_cnt, 32'd12);
    chk("perf_ins4", instr_cnt, 32'd4);
`endif
    do_reset();

    // Random instruction stream
    for (int k = 0; k < 300; k++) begin
      case ($urandom % 8)
        0:       op = 5'($urandom_range(15, 0));
        1:       op = 5'h10;
        2:       op = 5'h11;
        3:       op = 5'h12;
        4:       op = 5'h13;
        5:       op = 5'h14;
        6:       op = 5'($urandom_range(30, 21));
        default: op = ($urandom % 4 == 0) ? 5'h1F : 5'($urandom_range(15, 0));
      endcase
      ins = {16'($urandom), 1'($urandom), op, 2'($urandom)};
      di  = ($urandom % 20 == 0) ? TO : int'($urandom_range(2, 0));
      dd  = ($urandom % 20 == 0) ? TO : int'($urandom_range(3, 0));
      run_instr(ins, rb(), di, dd, hlt);
      if (hlt) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end

endmodule
